imm_inst_packer: RTL and testbench

- Inverse of the immediate generator: takes a 32-bit immediate plus an instruction "frame" and scatters the immediate bits into the RV32 I/U/S/B/J immediate fields.
- Produces an encoded instruction word and checks that the immediate is representable in the chosen format.
- Used by the trap-stub / self-test instruction builder ahead of the IFU's patch memory.
- Two-stage valid/ready pipeline with full backpressure and a saturating error counter.

---
 rtl/imm_inst_packer_if.sv | 25 ++
 rtl/imm_inst_packer.sv | 118 +++++++++++
 tb/tb_imm_inst_packer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/imm_inst_packer_if.sv
// Request/result bus of the immediate packer: a valid/ready request channel
// and a valid/ready result channel.
interface imm_inst_packer_if #(
    parameter int EXTOP_W = 3
);
    logic               in_valid;
    logic               in_ready;
    logic [EXTOP_W-1:0] in_extop;
    logic [31:0]        in_imm;
    logic [31:0]        in_frame;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_inst;
    logic               out_err;

    modport master (
        output in_valid, in_extop, in_imm, in_frame, out_ready,
        input  in_ready, out_valid, out_inst, out_err
    );

    modport slave (
        input  in_valid, in_extop, in_imm, in_frame, out_ready,
        output in_ready, out_valid, out_inst, out_err
    );
endinterface

// File: rtl/imm_inst_packer.sv
// Scatters a 32-bit immediate into the RV32 I/U/S/B/J fields of an instruction
// frame, flagging unrepresentable immediates. Two-stage valid/ready pipeline.
module imm_inst_packer #(
    parameter int ERR_CNT_W = 16,
    parameter int EXTOP_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    imm_inst_packer_if.slave     bus,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    typedef enum logic [EXTOP_W-1:0] {
        FMT_I = EXTOP_W'(0),
        FMT_U = EXTOP_W'(1),
        FMT_S = EXTOP_W'(2),
        FMT_B = EXTOP_W'(3),
        FMT_J = EXTOP_W'(4)
    } fmt_e;

    logic               s1_valid;
    logic [EXTOP_W-1:0] s1_extop;
    logic [31:0]        s1_imm;
    logic [31:0]        s1_frame;

    logic               s2_valid;
    logic [31:0]        s2_inst;
    logic               s2_err;

    logic               s2_adv;
    logic               fits11, fits12, fits20;
    logic [31:0]        pk_inst;
    logic               pk_err;

    assign s2_adv       = !s2_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_adv;
    assign bus.out_valid = s2_valid;
    assign bus.out_inst  = s2_inst;
    assign bus.out_err   = s2_err;

    // Sign-extension checks: upper bits must all replicate the field's sign bit.
    assign fits11 = (&s1_imm[31:11]) || !(|s1_imm[31:11]);
    assign fits12 = (&s1_imm[31:12]) || !(|s1_imm[31:12]);
    assign fits20 = (&s1_imm[31:20]) || !(|s1_imm[31:20]);

    always_comb begin
        pk_inst = s1_frame;
        pk_err  = 1'b0;
        case (s1_extop)
            FMT_I: begin
                pk_err         = !fits11;
                pk_inst[31:20] = s1_imm[11:0];
            end
            FMT_U: begin
                pk_err         = |s1_imm[11:0];
                pk_inst[31:12] = s1_imm[31:12];
            end
            FMT_S: begin
                pk_err         = !fits11;
                pk_inst[31:25] = s1_imm[11:5];
                pk_inst[11:7]  = s1_imm[4:0];
            end
            FMT_B: begin
                pk_err         = !fits12 || s1_imm[0];
                pk_inst[31]    = s1_imm[12];
                pk_inst[7]     = s1_imm[11];
                pk_inst[30:25] = s1_imm[10:5];
                pk_inst[11:8]  = s1_imm[4:1];
            end
            FMT_J: begin
                pk_err         = !fits20 || s1_imm[0];
                pk_inst[31]    = s1_imm[20];
                pk_inst[30:21] = s1_imm[10:1];
                pk_inst[20]    = s1_imm[11];
                pk_inst[19:12] = s1_imm[19:12];
            end
            default: pk_err = 1'b1;
        endcase
        if (pk_err) pk_inst = s1_frame;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_extop <= '0;
            s1_imm   <= '0;
            s1_frame <= '0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_extop <= bus.in_extop;
                s1_imm   <= bus.in_imm;
                s1_frame <= bus.in_frame;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_inst  <= '0;
            s2_err   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_inst <= pk_inst;
                s2_err  <= pk_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (s2_valid && bus.out_ready && s2_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_imm_inst_packer.sv
// Directed bench for imm_inst_packer: formats, errors, backpressure, reset and
// counter saturation (second instance with a 2-bit counter).
module tb_imm_inst_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    imm_inst_packer_if #(.EXTOP_W(3)) bus1 ();
    imm_inst_packer_if #(.EXTOP_W(3)) bus2 ();
    logic [15:0] cnt1;
    logic [1:0]  cnt2;

    imm_inst_packer #(.ERR_CNT_W(16), .EXTOP_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .err_cnt(cnt1)
    );
    imm_inst_packer #(.ERR_CNT_W(2), .EXTOP_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .err_cnt(cnt2)
    );

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request on bus1 and collects its result; lat = -1 on timeout.
    task automatic run_one(input logic [2:0] x, input logic [31:0] imm, input logic [31:0] frame,
                           output logic [31:0] inst, output logic err, output int lat);
        int w;
        bus1.in_extop = x; bus1.in_imm = imm; bus1.in_frame = frame; bus1.in_valid = 1'b1;
        w = 0;
        while (bus1.in_ready !== 1'b1 && w < 10) begin tick(); w++; end
        tick();
        bus1.in_valid = 1'b0;
        lat = 1;
        while (bus1.out_valid !== 1'b1 && lat < 10) begin tick(); lat++; end
        inst = bus1.out_inst;
        err  = bus1.out_err;
        if (bus1.out_valid !== 1'b1) lat = -1;
        tick();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus1.out_valid); end
        checks++; if (bus1.out_inst !== 32'h0) begin errors++; $display("FAIL rst_out_inst got %h want 00000000", bus1.out_inst); end
        checks++; if (bus1.out_err !== 1'b0) begin errors++; $display("FAIL rst_out_err got %b want 0", bus1.out_err); end
        checks++; if (cnt1 !== 16'd0) begin errors++; $display("FAIL rst_err_cnt got %0d want 0", cnt1); end
        rst_n = 1'b1;
        tick();
        checks++; if (bus1.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", bus1.in_ready); end
    endtask

    task automatic test_i_format();
        logic [31:0] inst; logic err; int lat;
        bus1.out_ready = 1'b1;
        run_one(3'd0, 32'hFFFF_FFFF, 32'h0000_0013, inst, err, lat);
        checks++; if (inst !== 32'hFFF0_0013) begin errors++; $display("FAIL i_inst got %h want fff00013", inst); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL i_err got %b want 0", err); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL i_latency got %0d want 2", lat); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ex [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic [31:0] im [4] = '{32'h1234_5000, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0000_0800};
        logic [31:0] fr [4] = '{32'h0000_0037, 32'h0000_2023, 32'h0000_0063, 32'h0000_006F};
        logic [31:0] ex_inst [4] = '{32'h1234_5037, 32'hFE00_2E23, 32'h0000_0463, 32'h0010_006F};
        int k = 0;
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus1.out_valid !== 1'((i >= 2) && (i < 6))) begin errors++; $display("FAIL b2b_valid cyc %0d got %b", i, bus1.out_valid); end
            if (bus1.out_valid === 1'b1 && k < 4) begin
                checks++; if (bus1.out_inst !== ex_inst[k]) begin errors++; $display("FAIL b2b_inst %0d got %h want %h", k, bus1.out_inst, ex_inst[k]); end
                checks++; if (bus1.out_err !== 1'b0) begin errors++; $display("FAIL b2b_err %0d got %b want 0", k, bus1.out_err); end
                k++;
            end
            if (i < 4) begin
                bus1.in_extop = ex[i]; bus1.in_imm = im[i]; bus1.in_frame = fr[i]; bus1.in_valid = 1'b1;
            end else begin
                bus1.in_valid = 1'b0;
            end
            tick();
        end
        checks++; if (k !== 4) begin errors++; $display("FAIL b2b_count got %0d want 4", k); end
    endtask

    task automatic test_errors();
        logic [31:0] inst; logic err; int lat;
        bus1.out_ready = 1'b1;
        run_one(3'd3, 32'h0000_0003, 32'h0000_0063, inst, err, lat);
        checks++; if (inst !== 32'h0000_0063) begin errors++; $display("FAIL errb_inst got %h want 00000063", inst); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL errb_err got %b want 1", err); end
        checks++; if (cnt1 !== 16'd1) begin errors++; $display("FAIL errb_cnt got %0d want 1", cnt1); end
        run_one(3'd0, 32'h0000_0800, 32'h0000_0013, inst, err, lat);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL erri_err got %b want 1", err); end
        checks++; if (inst !== 32'h0000_0013) begin errors++; $display("FAIL erri_inst got %h want 00000013", inst); end
        checks++; if (cnt1 !== 16'd2) begin errors++; $display("FAIL erri_cnt got %0d want 2", cnt1); end
        run_one(3'd6, 32'h0000_0000, 32'h0000_0033, inst, err, lat);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL errx_err got %b want 1", err); end
        checks++; if (cnt1 !== 16'd3) begin errors++; $display("FAIL errx_cnt got %0d want 3", cnt1); end
    endtask

    task automatic test_backpressure();
        logic [31:0] ex_inst [3] = '{32'h0050_0013, 32'hABCD_E037, 32'h0000_2823};
        int k = 0;
        logic c_taken = 1'b0;
        bus1.out_ready = 1'b0;
        bus1.in_extop = 3'd0; bus1.in_imm = 32'd5; bus1.in_frame = 32'h13; bus1.in_valid = 1'b1;
        checks++; if (bus1.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_a got %b want 1", bus1.in_ready); end
        tick();
        bus1.in_extop = 3'd1; bus1.in_imm = 32'hABCD_E000; bus1.in_frame = 32'h37;
        checks++; if (bus1.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_b got %b want 1", bus1.in_ready); end
        tick();
        bus1.in_extop = 3'd2; bus1.in_imm = 32'h10; bus1.in_frame = 32'h2023;
        checks++; if (bus1.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_c got %b want 0", bus1.in_ready); end
        checks++; if (bus1.out_inst !== ex_inst[0]) begin errors++; $display("FAIL bp_hold0 got %h want %h", bus1.out_inst, ex_inst[0]); end
        tick(); tick();
        checks++; if (bus1.out_inst !== ex_inst[0] || bus1.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold2 got %h/%b want %h/1", bus1.out_inst, bus1.out_valid, ex_inst[0]); end
        checks++; if (bus1.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_held got %b want 0", bus1.in_ready); end
        bus1.out_ready = 1'b1;
        #1;
        for (int cyc = 0; cyc < 12 && k < 3; cyc++) begin
            if (bus1.out_valid === 1'b1) begin
                checks++; if (bus1.out_inst !== ex_inst[k]) begin errors++; $display("FAIL bp_order %0d got %h want %h", k, bus1.out_inst, ex_inst[k]); end
                k++;
            end
            if (bus1.in_valid === 1'b1 && bus1.in_ready === 1'b1) c_taken = 1'b1;
            tick();
            if (c_taken) bus1.in_valid = 1'b0;
        end
        checks++; if (k !== 3) begin errors++; $display("FAIL bp_count got %0d want 3", k); end
        tick();
        checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup got %b want 0", bus1.out_valid); end
    endtask

    task automatic test_reset_midflight();
        bus1.out_ready = 1'b0;
        bus1.in_extop = 3'd7; bus1.in_imm = 32'd0; bus1.in_frame = 32'h13; bus1.in_valid = 1'b1;
        tick(); tick();
        bus1.in_valid = 1'b0;
        checks++; if (bus1.out_valid !== 1'b1 || bus1.in_ready !== 1'b0) begin errors++; $display("FAIL mid_full got %b/%b want 1/0", bus1.out_valid, bus1.in_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %b want 0", bus1.out_valid); end
        checks++; if (cnt1 !== 16'd0) begin errors++; $display("FAIL mid_err_cnt got %0d want 0", cnt1); end
        rst_n = 1'b1;
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale cyc %0d got %b want 0", i, bus1.out_valid); end
        end
        checks++; if (bus1.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b want 1", bus1.in_ready); end
    endtask

    task automatic test_saturation();
        logic [1:0] want;
        int w;
        bus2.out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            bus2.in_extop = 3'd7; bus2.in_imm = 32'd0; bus2.in_frame = 32'h13; bus2.in_valid = 1'b1;
            tick();
            bus2.in_valid = 1'b0;
            w = 0;
            while (bus2.out_valid !== 1'b1 && w < 10) begin tick(); w++; end
            checks++; if (bus2.out_valid !== 1'b1 || bus2.out_err !== 1'b1) begin errors++; $display("FAIL sat_result %0d got %b/%b want 1/1", n, bus2.out_valid, bus2.out_err); end
            tick();
            want = (n >= 2) ? 2'd3 : 2'(n + 1);
            checks++; if (cnt2 !== want) begin errors++; $display("FAIL sat_cnt %0d got %0d want %0d", n, cnt2, want); end
        end
    endtask

    initial begin
        bus1.in_valid = 1'b0; bus1.in_extop = '0; bus1.in_imm = '0; bus1.in_frame = '0; bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_extop = '0; bus2.in_imm = '0; bus2.in_frame = '0; bus2.out_ready = 1'b0;
        test_reset();
        test_i_format();
        test_back_to_back();
        test_errors();
        test_backpressure();
        test_reset_midflight();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
